// File: rtl/tm1638_time_display.sv
// rtl/tm1638_time_display.sv - TM1638 MM.SS display driver (optional TM_COLON_BLINK_EN)
module tm1638_time_display #(
    parameter int         CLK_DIV = 50,
    parameter logic [2:0] BRIGHT  = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(CLK_DIV + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_BIT_LO = 3'd2;
    localparam logic [2:0] S_BIT_HI = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    txn;
    logic [4:0]    bidx;
    logic [2:0]    bitn;
    logic [5:0]    snap_min;
    logic [5:0]    snap_sec;
    logic          force_f;

    logic          cnt_last;
    logic [4:0]    last_byte;
    logic [4:0]    nx_bidx;
    logic [2:0]    nx_bitn;
    logic [7:0]    nx_byte;
    logic          dp;

    // Tens digit by compare chain; 60..63 yields 6 as the counter can reach 60.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] v);
        logic [5:0] r;
        r = v - (6'(tens_of(v)) * 6'd10);
        return r[3:0];
    endfunction

    // Common-cathode gfedcba patterns.
    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

`ifdef TM_COLON_BLINK_EN
    assign dp = ~snap_sec[0];
`else
    assign dp = 1'b0;
`endif

    assign cnt_last   = (cnt == CW'(CLK_DIV - 1));
    assign last_byte  = (txn == 2'd1) ? 5'd16 : 5'd0;
    assign frame_done = (state == S_GAP) && cnt_last && (txn == 2'd2);

    // Select the byte/bit that goes on tm_dio at the next tm_clk falling edge.
    always_comb begin
        nx_bidx = bidx;
        nx_bitn = 3'd0;
        if (state == S_BIT_HI) begin
            if (bitn == 3'd7) nx_bidx = bidx + 5'd1;
            else              nx_bitn = bitn + 3'd1;
        end
        nx_byte = 8'h00;
        case (txn)
            2'd0: nx_byte = 8'h40;
            2'd2: nx_byte = {5'b10001, BRIGHT};
            default: begin
                case (nx_bidx)
                    5'd0:    nx_byte = 8'hC0;
                    5'd1:    nx_byte = seg(tens_of(snap_min));
                    5'd3:    nx_byte = seg(units_of(snap_min)) | {dp, 7'd0};
                    5'd5:    nx_byte = seg(tens_of(snap_sec));
                    5'd7:    nx_byte = seg(units_of(snap_sec));
                    default: nx_byte = 8'h00;
                endcase
            end
        endcase
    end

    // Frame sequencer: trigger, three strobed transactions, bit-level bus timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            txn      <= 2'd0;
            bidx     <= 5'd0;
            bitn     <= 3'd0;
            snap_min <= 6'd0;
            snap_sec <= 6'd0;
            force_f  <= 1'b1;
            busy     <= 1'b0;
            tm_stb   <= 1'b1;
            tm_clk   <= 1'b1;
            tm_dio   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (force_f || ({min, sec} != {snap_min, snap_sec})) begin
                        snap_min <= min;
                        snap_sec <= sec;
                        force_f  <= 1'b0;
                        busy     <= 1'b1;
                        tm_stb   <= 1'b0;
                        txn      <= 2'd0;
                        bidx     <= 5'd0;
                        bitn     <= 3'd0;
                        cnt      <= '0;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_last) begin
                        cnt    <= '0;
                        tm_clk <= 1'b0;
                        tm_dio <= nx_byte[nx_bitn];
                        state  <= S_BIT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BIT_LO: begin
                    if (cnt_last) begin
                        cnt    <= '0;
                        tm_clk <= 1'b1;
                        state  <= S_BIT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BIT_HI: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (bitn == 3'd7 && bidx == last_byte) begin
                            state <= S_HOLD;
                        end else begin
                            bidx   <= nx_bidx;
                            bitn   <= nx_bitn;
                            tm_clk <= 1'b0;
                            tm_dio <= nx_byte[nx_bitn];
                            state  <= S_BIT_LO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_last) begin
                        cnt    <= '0;
                        tm_stb <= 1'b1;
                        tm_dio <= 1'b1;
                        state  <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (txn == 2'd2) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            txn    <= txn + 2'd1;
                            bidx   <= 5'd0;
                            bitn   <= 3'd0;
                            tm_stb <= 1'b0;
                            state  <= S_SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_time_display.sv
// tb/tb_tm1638_time_display.sv - randomized bus-decoding bench for tm1638_time_display
module tb_tm1638_time_display;

    localparam int CD = 2;
    localparam int FRAME_CYC = 313 * CD;

    logic       clk;
    logic       rst_n;
    logic [5:0] sec;
    logic [5:0] min;
    logic       tm_stb;
    logic       tm_clk;
    logic       tm_dio;
    logic       busy;
    logic       frame_done;

    int checks;
    int failures;

    tm1638_time_display #(.CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .sec(sec), .min(min),
        .tm_stb(tm_stb), .tm_clk(tm_clk), .tm_dio(tm_dio),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what the display should show for a given minute/second pair.
    function automatic int exp_byte(input int i, input int m, input int s);
        int segs [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
        int blink;
`ifdef TM_COLON_BLINK_EN
        blink = ((s % 2) == 0) ? 'h80 : 0;
`else
        blink = 0;
`endif
        if (i == 0)  return 'h40;
        if (i == 1)  return 'hC0;
        if (i == 18) return 'h88 | 7;
        case (i - 2)
            0:       return segs[m / 10];
            2:       return segs[m % 10] | blink;
            4:       return segs[s / 10];
            6:       return segs[s % 10];
            default: return 0;
        endcase
    endfunction

    // Bus monitor: decodes bytes and measures edge spacing, sampled on negedge.
    logic [7:0] fbytes [$];
    logic [7:0] got [$];
    logic [7:0] shreg;
    int bits, cyc, viol, frames, done_pulses;
    int stb_fall, stb_rise, last_fall, last_rise, edges;
    int busy_run, low_run, got_len, last_low;
    logic prev_stb, prev_clk, prev_busy;

    initial begin
        frames = 0; done_pulses = 0; viol = 0; cyc = 0;
        prev_stb = 1'b1; prev_clk = 1'b1; prev_busy = 1'b0;
        bits = 0; edges = 0; busy_run = 0; low_run = 0; last_low = -1;
        stb_rise = -1000; stb_fall = 0; last_fall = 0; last_rise = 0; shreg = 8'h00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            fbytes.delete();
            prev_stb = 1'b1; prev_clk = 1'b1; prev_busy = 1'b0;
            bits = 0; edges = 0; busy_run = 0; low_run = 0;
            stb_rise = -1000; cyc = 0;
        end else begin
            cyc++;
            if (busy) begin
                if (!prev_busy) last_low = low_run;
                busy_run++;
                low_run = 0;
            end else begin
                busy_run = 0;
                low_run++;
            end
            if (tm_stb && (!tm_clk || !tm_dio)) viol++;
            if (prev_stb && !tm_stb) begin
                if (fbytes.size() > 0 && cyc - stb_rise != CD) viol++;
                stb_fall = cyc; edges = 0; bits = 0;
            end
            if (!tm_stb && prev_clk && !tm_clk) begin
                if (edges == 0) begin
                    if (cyc - stb_fall != CD) viol++;
                end else if (cyc - last_rise != CD) viol++;
                last_fall = cyc;
            end
            if (!tm_stb && !prev_clk && tm_clk) begin
                if (cyc - last_fall != CD) viol++;
                shreg = {tm_dio, shreg[7:1]};
                bits++; edges++;
                if (bits == 8) begin
                    fbytes.push_back(shreg);
                    bits = 0;
                end
                last_rise = cyc;
            end
            if (!prev_stb && tm_stb) begin
                if (cyc - last_rise != 2 * CD) viol++;
                stb_rise = cyc;
            end
            if (frame_done) begin
                done_pulses++;
                got = fbytes;
                got_len = busy_run;
                fbytes.delete();
                frames++;
            end
            prev_stb = tm_stb; prev_clk = tm_clk; prev_busy = busy;
        end
    end

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames < target && t < 3 * FRAME_CYC) begin
            @(negedge clk);
            t++;
        end
        check("frame_arrived", frames, target);
    endtask

    task automatic compare_frame(input string tag, input int m, input int s);
        check({tag, "_nbytes"}, got.size(), 19);
        for (int i = 0; i < 19; i++)
            if (i < got.size())
                check($sformatf("%s_b%0d", tag, i), got[i], exp_byte(i, m, s));
        check({tag, "_len"}, got_len, FRAME_CYC);
    endtask

    task automatic send(input string tag, input int m, input int s);
        int n;
        n = frames;
        @(negedge clk);
        min = 6'(m); sec = 6'(s);
        wait_frames(n + 1);
        compare_frame(tag, m, s);
        repeat (3) @(negedge clk);
    endtask

    int cur_m, cur_s, n0;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; min = 6'd0; sec = 6'd0;
        repeat (3) @(negedge clk);
        check("reset_outs", {tm_stb, tm_clk, tm_dio, busy, frame_done}, 5'b11100);

        rst_n = 1'b1;
        @(posedge clk); #1;
        check("start_stb", tm_stb, 0);
        check("start_busy", busy, 1);
        wait_frames(1);
        compare_frame("first", 0, 0);
        check("done_pulses", done_pulses, 1);
        check("timing_first", viol, 0);
        repeat (FRAME_CYC + 50) @(negedge clk);
        check("no_refire", frames, 1);
        check("idle_busy", busy, 0);

        send("m12s59", 12, 59);
        send("m60s00", 60, 0);
        send("m63s63", 63, 63);
        cur_m = 63; cur_s = 63;
        for (int k = 0; k < 6; k++) begin
            int m, s;
            m = $urandom_range(0, 63);
            s = $urandom_range(0, 63);
            if (m == cur_m && s == cur_s) s = (s + 1) % 64;
            send($sformatf("rnd%0d", k), m, s);
            cur_m = m; cur_s = s;
        end

        // Mid-frame changes: only the snapshot value and then the latest value appear.
        n0 = frames;
        @(negedge clk);
        min = 6'd21; sec = 6'd5;
        repeat (70) @(negedge clk);
        sec = 6'd6;
        repeat (100) @(negedge clk);
        sec = 6'd7;
        wait_frames(n0 + 1);
        compare_frame("mid_old", 21, 5);
        wait_frames(n0 + 2);
        compare_frame("mid_new", 21, 7);
        check("mid_gap", last_low, 1);
        repeat (FRAME_CYC + 50) @(negedge clk);
        check("mid_no_third", frames, n0 + 2);

        // Asynchronous reset in the middle of T2.
        @(negedge clk);
        min = 6'd33; sec = 6'd44;
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_outs", {tm_stb, tm_clk, tm_dio, busy}, 4'b1110);
        n0 = frames;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        wait_frames(n0 + 1);
        compare_frame("post_rst", 33, 44);
        check("timing_post_rst", viol, 0);

        send("colon_s0", 0, 0);
        send("colon_s1", 0, 1);
        check("timing_all", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tm1638_time_display.md
Name: tm1638_time_display

Overview:
- Downstream stage of the minutes/seconds counter. Takes the binary minute and second values (0..63 each) and drives a TM1638 display module over its 3-wire serial bus (STB, CLK, DIO), write-only.
- Shows MM.SS on digits 1-4. Digits 5-8 and all LEDs are blank.
- Sends a full refresh frame after reset, and again whenever the input values change.

Parameters:
- CLK_DIV, 50, half-period of tm_clk in clk cycles (must be >=1; 50 MHz clk gives a 500 kHz bus).
- BRIGHT, 7, 3-bit brightness field placed in the display-control command.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sec  input  6  seconds value from counter (binary).
- min  input  6  minutes value from counter (binary).
- tm_stb  output  1  TM1638 strobe, active-low frame select.
- tm_clk  output  1  TM1638 serial clock; idles high.
- tm_dio  output  1  TM1638 serial data; LSB first.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of a frame.

Behaviour:
- Reset (async, rst_n=0) values:
  - tm_stb=1, tm_clk=1, tm_dio=1, busy=0, frame_done=0.
  - Snapshot registers cleared.
  - force flag set.
- IDLE trigger and frame start:
  - A frame starts on the clk edge where force=1 or {min,sec} != snapshot.
  - On that edge: latch snapshot <= {min,sec}, clear force, set busy=1, tm_stb<=0.
  - After reset, the first rising clk edge with rst_n=1 therefore starts a frame.
- Frame = three strobed transactions, in order:
  - T1: 0x40 (data write, auto-increment).
  - T2: 0xC0, then 16 data bytes.
  - T3: 0x88|BRIGHT.
- Transaction timing:
  - STB low, then CLK_DIV cycles of setup.
  - Each bit: tm_clk low for CLK_DIV cycles (tm_dio updated on the cycle tm_clk falls), then high for CLK_DIV cycles. The TM1638 samples on the rising edge.
  - After the last bit: CLK_DIV cycles of hold, tm_stb=1, then an STB-high gap of CLK_DIV cycles.
  - tm_dio returns to 1 whenever tm_stb=1.
- Transaction length, with n = byte count: (2+16n)*CLK_DIV + CLK_DIV cycles.
- Frame length is exactly 313*CLK_DIV cycles:
  - T1: 19*CLK_DIV.
  - T2: 275*CLK_DIV.
  - T3: 19*CLK_DIV.
- End of frame: frame_done pulses on the final gap cycle; busy drops on the next edge (IDLE).
- Data bytes (index 0..15 after 0xC0):
  - 0 = seg(min/10)
  - 2 = seg(min%10)
  - 4 = seg(sec/10)
  - 6 = seg(sec%10)
  - All odd bytes and bytes 8, 10, 12, 14 = 0x00.
  - Values are taken from the snapshot, never from live inputs.
- Segment table (gfedcba, common cathode), digits 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- Values 60..63: tens digit 6, units digit 0..3 (the counter legitimately reaches 60).
- Input changes mid-frame: ignored until IDLE. A new frame then starts on the edge after busy falls if {min,sec} differs from the snapshot. Only the latest value is sent; intermediate values are lost.
- Reset mid-frame: outputs return to reset values immediately. A full new frame is sent after release.
- Arithmetic: /10 and %10 are implemented on 6-bit values by lookup or compare-subtract. No multi-cycle divider; the result must be ready within the same cycle as byte load.

Optional Feature:
- Macro: TM_COLON_BLINK_EN.
- Defined: bit 7 (DP) of data byte 2 = ~snapshot_sec[0]. This gives a blinking separator at 0.5 Hz when seconds tick at 1 Hz.
- Undefined: byte 2 bit 7 always 0. Frame length and all other bytes are unchanged.

Test Plan:
- Reset release, sec=0, min=0, CLK_DIV=2 -> tm_stb falls on first edge; frame lasts 626 cycles. Decoded bytes:
  - 40
  - C0 3F 00 3F 00 3F 00 3F 00 00 00 00 00 00 00 00 00
  - 8F
  - frame_done pulses once; no second frame follows.
- Idle, then min=12 sec=59 -> new frame with byte0=06, byte2=5B, byte4=6D, byte6=6F.
- min=60 sec=0 -> bytes 7D,3F,3F,3F. Also min=63 sec=63 -> 7D,4F,7D,4F.
- sec changes 5->6->7 during T2 of a frame -> that frame still shows 5. Exactly one further frame follows, showing 7. busy is low for exactly one cycle between the frames.
- rst_n pulsed low midway through T2 -> outputs 1/1/1 and busy=0 asynchronously. After release, a full 313*CLK_DIV frame is sent. Check the timing of every tm_clk edge relative to tm_stb (setup/hold = CLK_DIV).
- With TM_COLON_BLINK_EN defined, min=0: sec=0 -> byte2=BF; sec=1 -> byte2=3F. With the macro undefined, sec=0 -> byte2=3F.
